irq_controller: RTL

- Parametrised interrupt source unit that drives the 32-bit interrupt vector into the datapath's CSR interrupt input.
- Generalises the present fixed 64-cycle timer interrupt and single one-shot UART interrupt to:
  - a programmable-period timer;
  - N_EXT level-input external channels with rising-edge capture;
  - per-source pending latches;
  - a pulse-then-acknowledge handshake, so mepc is written exactly once per taken interrupt.

---
 rtl/irq_pkg.sv | 35 +++
 rtl/irq_timer.sv | 37 +++
 rtl/irq_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt source unit.
//   irq_state_e : issue FSM state (idle / one-cycle issue / wait for acknowledge)
//   MTIP_BIT, MEIP_BIT, EXT_ID_BASE : default vector bit positions
//   irq_vector() : builds the interrupt vector for a winning source index
//                  (index 0 = timer, index k+1 = external channel k)
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } irq_state_e;

  localparam int unsigned MTIP_BIT    = 7;
  localparam int unsigned MEIP_BIT    = 11;
  localparam int unsigned EXT_ID_BASE = 16;

  // Widest vector the helper can build; callers slice down to their width.
  localparam int unsigned VecMaxW = 64;

  function automatic logic [VecMaxW-1:0] irq_vector(input int unsigned idx,
                                                    input int unsigned timer_bit,
                                                    input int unsigned ext_bit,
                                                    input int unsigned ext_id_base);
    logic [VecMaxW-1:0] v;
    if (idx == 0) begin
      v = 64'd1 << timer_bit;
    end else begin
      // External channels raise the shared MEIP bit plus their own id bit.
      v = (64'd1 << ext_bit) | (64'd1 << (ext_id_base + idx - 1));
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Programmable-period timer.
//   clk, reset : clock, synchronous active-high reset
//   en         : count enable
//   period     : terminal count; interval is period+1 cycles, 0 disables
//   count      : current counter value (registered)
//   tick       : high in the cycle the counter equals the terminal count
module irq_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [TIMER_W-1:0] period,
  output logic [TIMER_W-1:0] count,
  output logic               tick
);

  logic [TIMER_W-1:0] count_q;
  logic               active;

  assign active = en && (period != '0);
  // A lowered period takes effect at the next match; until then the counter
  // simply runs on and wraps at 2^TIMER_W.
  assign tick   = active && (count_q == period);
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (!active || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source unit driving the CSR interrupt vector.
//   clk, reset   : clock, synchronous active-high reset
//   timer_en     : timer count enable
//   timer_period : timer terminal count (interval = period+1 cycles)
//   ext_src      : level external sources, rising-edge captured
//   ext_en       : per-channel capture / issue enable
//   irq_ack      : in-service interrupt finished (honoured only while waiting)
//   interrupt    : one-cycle vector pulse
//   busy         : an interrupt is issued and not yet acknowledged
//   pending      : pending latches, bit 0 timer, bit k+1 channel k
//   overrun      : sticky, event arrived while the same source was pending
//   timer_count  : current timer value
module irq_controller #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned N_EXT       = 2,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned TIMER_BIT   = irq_pkg::MTIP_BIT,
  parameter int unsigned EXT_BIT     = irq_pkg::MEIP_BIT,
  parameter int unsigned EXT_ID_BASE = irq_pkg::EXT_ID_BASE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               timer_en,
  input  logic [TIMER_W-1:0] timer_period,
  input  logic [N_EXT-1:0]   ext_src,
  input  logic [N_EXT-1:0]   ext_en,
  input  logic               irq_ack,
  output logic [WIDTH-1:0]   interrupt,
  output logic               busy,
  output logic [N_EXT:0]     pending,
  output logic [N_EXT:0]     overrun,
  output logic [TIMER_W-1:0] timer_count
);

  import irq_pkg::*;

  localparam int unsigned NSrc = N_EXT + 1;

  if (EXT_ID_BASE + N_EXT > WIDTH) begin : g_bad_cfg
    $error("irq_controller: EXT_ID_BASE + N_EXT exceeds WIDTH");
  end

  logic timer_tick;

  irq_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (timer_en),
    .period(timer_period),
    .count (timer_count),
    .tick  (timer_tick)
  );

  logic [N_EXT-1:0]   src_q;
  logic [N_EXT-1:0]   ext_edge;
  logic [NSrc-1:0]    set_v;
  logic [NSrc-1:0]    clr_v;
  logic [NSrc-1:0]    eligible;
  logic [NSrc-1:0]    pending_q, pending_d;
  logic [NSrc-1:0]    overrun_q, overrun_d;
  irq_state_e         state_q, state_d;
  logic [WIDTH-1:0]   interrupt_q, interrupt_d;
  logic [VecMaxW-1:0] vec_full;
  logic               busy_q;

  assign ext_edge = ext_src & ~src_q & ext_en;
  assign set_v    = {ext_edge, timer_tick};
  // Disabled channels keep their pending bit but cannot win arbitration.
  assign eligible = pending_q & {ext_en, 1'b1};

  always_comb begin
    state_d     = state_q;
    clr_v       = '0;
    vec_full    = '0;
    interrupt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d = StIssue;
          // Descending scan so the lowest index (highest priority) wins.
          for (int i = NSrc - 1; i >= 0; i--) begin
            if (eligible[i]) begin
              clr_v    = NSrc'(1) << i;
              vec_full = irq_vector(unsigned'(i), TIMER_BIT, EXT_BIT, EXT_ID_BASE);
            end
          end
          interrupt_d = vec_full[WIDTH-1:0];
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (irq_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new event beats the issue-clear; re-arrival on a bit that stays
    // pending is an overrun.
    pending_d = (pending_q & ~clr_v) | set_v;
    overrun_d = overrun_q | (set_v & pending_q & ~clr_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q       <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      state_q     <= StIdle;
      interrupt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      src_q       <= ext_src;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule
